fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/sys_defs.sv | 26 ++
 rtl/fetch_predecode.sv | 17 +
 rtl/fetch_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared fetch definitions: stage state enum, IF->IB packet and the
// J-immediate helper used by the optional JAL predecoder.
package sys_defs;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_DROP
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } IF_IB_PACKET;

  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20],
            inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Next-PC predecode: follows a JAL to its target, otherwise pc+4.
// Only instantiated when FETCH_JAL_PREDICT_EN is defined.
module fetch_predecode
  import sys_defs::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_npc
);

  logic w_is_jal;

  assign w_is_jal = (i_inst[6:0] == OP_JAL);
  assign o_npc    = w_is_jal ? i_pc + j_imm(i_inst)
                             : i_pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding doubleword request, one packet.
// Optional JAL next-PC prediction under FETCH_JAL_PREDICT_EN.
module fetch_stage
  import sys_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        ib_full_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [63:0] mem_rdata_in,
  output IF_IB_PACKET if_ib_packet
);

  fetch_state_t r_state, w_next;
  logic [31:0]  r_pc, w_pc_nxt;
  IF_IB_PACKET  r_pkt, w_pkt_nxt;
  logic [31:0]  w_inst;
  logic [31:0]  w_npc;

  assign w_inst = r_pc[2] ? mem_rdata_in[63:32]
                          : mem_rdata_in[31:0];

`ifdef FETCH_JAL_PREDICT_EN
  fetch_predecode u_predecode (
    .i_pc   (r_pc),
    .i_inst (w_inst),
    .o_npc  (w_npc)
  );
`else
  assign w_npc = r_pc + 32'd4;
`endif

  always_comb begin
    w_next    = r_state;
    w_pc_nxt  = r_pc;
    w_pkt_nxt = r_pkt;
    if (squash_in) begin
      w_pc_nxt        = redirect_pc_in;
      w_pkt_nxt.valid = 1'b0;
      // a granted request must still drain its response
      unique case (r_state)
        FS_REQ:  w_next = mem_gnt_in ? FS_DROP : FS_REQ;
        FS_WAIT: w_next = mem_rvalid_in ? FS_REQ : FS_DROP;
        FS_HOLD: w_next = FS_REQ;
        FS_DROP: w_next = mem_rvalid_in ? FS_REQ : FS_DROP;
        default: w_next = FS_REQ;
      endcase
    end else begin
      unique case (r_state)
        FS_REQ: begin
          if (mem_gnt_in) w_next = FS_WAIT;
        end
        FS_WAIT: begin
          if (mem_rvalid_in) begin
            w_pkt_nxt = '{valid: 1'b1, inst: w_inst,
                          pc: r_pc, npc: w_npc};
            w_next    = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (!ib_full_in) begin
            w_pc_nxt        = r_pkt.npc;
            w_pkt_nxt.valid = 1'b0;
            w_next          = FS_REQ;
          end
        end
        FS_DROP: begin
          if (mem_rvalid_in) w_next = FS_REQ;
        end
        default: w_next = FS_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FS_REQ;
      r_pc    <= RESET_PC;
      r_pkt   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      r_pkt   <= w_pkt_nxt;
    end
  end

  assign mem_req_out  = (r_state == FS_REQ);
  assign mem_addr_out = {r_pc[31:3], 3'b000};
  assign if_ib_packet = r_pkt;

endmodule
